// File: rtl/apuracao_votos.sv
// apuracao_votos: edge-detected vote tally, 4-cycle sequential winner search and stepped result display
module apuracao_votos #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 candidatoArthur,
  input  logic                 candidatoLeandro,
  input  logic                 candidatoMateus,
  input  logic                 candidatoPablo,
  input  logic                 candidatoNulo,
  input  logic                 finish,
  input  logic                 proximo,
  output logic [1:0]           estado_apuracao,
  output logic [2:0]           indice,
  output logic [CNT_WIDTH-1:0] contagem,
  output logic [CNT_WIDTH-1:0] total,
  output logic [2:0]           vencedor,
  output logic                 empate,
  output logic                 saturado
);
  typedef enum logic [1:0] {VOTACAO = 2'b00, APURANDO = 2'b01, EXIBINDO = 2'b10} estado_t;
  localparam logic [CNT_WIDTH-1:0] MAX = '1;
  estado_t estado;
  logic [CNT_WIDTH-1:0] cnt [5];
  logic [CNT_WIDTH-1:0] cnt_next [5];
  logic [4:0] flags, prev, rise;
  logic [2:0] n_rise;
  logic [CNT_WIDTH+2:0] t_sum;
  logic [CNT_WIDTH-1:0] total_next, sel, best, best_next;
  logic hit, prox_prev, gt, tie, tie_next;
  logic [1:0] step;
  logic [2:0] idx, idx_next;
  assign flags = {candidatoNulo, candidatoPablo, candidatoMateus, candidatoLeandro, candidatoArthur};
  assign rise = flags & ~prev;
  assign n_rise = 3'($countones(rise));
  // three spare bits absorb up to five simultaneous rises on top of a full total
  assign t_sum = {3'b0, total} + {{CNT_WIDTH{1'b0}}, n_rise};
  assign total_next = t_sum >= {3'b0, MAX} ? MAX : t_sum[CNT_WIDTH-1:0];
  assign estado_apuracao = estado;
  always_comb begin
    hit = total_next == MAX;
    for (int i = 0; i < 5; i++) begin
      cnt_next[i] = (rise[i] && cnt[i] != MAX) ? cnt[i] + 1'b1 : cnt[i];
      hit = hit | (cnt_next[i] == MAX);
    end
  end
  assign sel = cnt[{1'b0, step}];
  assign gt = sel > best;
  assign best_next = gt ? sel : best;
  assign idx_next = gt ? {1'b0, step} : idx;
  assign tie_next = gt ? 1'b0 : (sel == best && best != '0) ? 1'b1 : tie;
  assign contagem = indice < 3'd5 ? cnt[indice] : indice == 3'd5 ? total : '0;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= VOTACAO;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
      total <= '0;
      prev <= '0;
      prox_prev <= 1'b0;
      saturado <= 1'b0;
      indice <= '0;
      vencedor <= 3'd7;
      empate <= 1'b0;
      step <= '0;
      best <= '0;
      idx <= 3'd7;
      tie <= 1'b0;
    end else begin
      prev <= flags;
      prox_prev <= proximo;
      case (estado)
        VOTACAO: begin
          cnt <= cnt_next;
          total <= total_next;
          saturado <= saturado | hit;
          if (finish) begin
            estado <= APURANDO;
            step <= '0;
            best <= '0;
            idx <= 3'd7;
            tie <= 1'b0;
          end
        end
        APURANDO: begin
          step <= step + 2'd1;
          best <= best_next;
          idx <= idx_next;
          tie <= tie_next;
          if (step == 2'd3) begin
            vencedor <= tie_next ? 3'd7 : idx_next;
            empate <= tie_next;
            indice <= '0;
            estado <= EXIBINDO;
          end
        end
        EXIBINDO: if (proximo && !prox_prev) indice <= indice == 3'd5 ? 3'd0 : indice + 3'd1;
        default: estado <= VOTACAO;
      endcase
    end
  end
endmodule

// File: tb/tb_apuracao_votos.sv
// tb_apuracao_votos: scoreboard bench for the vote tally, run on 8-bit and 2-bit counter instances
module tb_apuracao_votos;
  logic clock = 0, reset = 1;
  logic [4:0] votes = 0;
  logic finish = 0, proximo = 0;
  logic [1:0] estado, estado2;
  logic [2:0] indice, indice2, vencedor, vencedor2;
  logic [7:0] contagem, total;
  logic [1:0] contagem2, total2;
  logic empate, saturado, empate2, saturado2;

  apuracao_votos #(.CNT_WIDTH(8)) dut (
    .clock(clock), .reset(reset),
    .candidatoArthur(votes[0]), .candidatoLeandro(votes[1]), .candidatoMateus(votes[2]),
    .candidatoPablo(votes[3]), .candidatoNulo(votes[4]),
    .finish(finish), .proximo(proximo),
    .estado_apuracao(estado), .indice(indice), .contagem(contagem), .total(total),
    .vencedor(vencedor), .empate(empate), .saturado(saturado)
  );

  apuracao_votos #(.CNT_WIDTH(2)) dut2 (
    .clock(clock), .reset(reset),
    .candidatoArthur(votes[0]), .candidatoLeandro(votes[1]), .candidatoMateus(votes[2]),
    .candidatoPablo(votes[3]), .candidatoNulo(votes[4]),
    .finish(finish), .proximo(proximo),
    .estado_apuracao(estado2), .indice(indice2), .contagem(contagem2), .total(total2),
    .vencedor(vencedor2), .empate(empate2), .saturado(saturado2)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {int cyc; int venc; int emp; int tot; int sat; int c0; int venc2; int emp2; int tot2; int sat2; int c02;} res_t;
  typedef struct {int idx; int c; int c2;} disp_t;
  res_t res_q[$];
  disp_t disp_q[$];

  int m_cnt[5], m_cnt2[5];
  int m_tot, m_tot2, m_sat, m_sat2, m_state, m_k, m_idx;
  logic [4:0] m_prev;
  logic m_pprev;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void win(input int a0, input int a1, input int a2, input int a3, output int v, output int e);
    int c[4] = '{a0, a1, a2, a3};
    int m = 0, n = 0;
    v = 7;
    e = 0;
    foreach (c[i]) if (c[i] > m) m = c[i];
    foreach (c[i]) if (c[i] == m && m > 0) begin n++; v = i; end
    if (n > 1) begin v = 7; e = 1; end
  endfunction

  function automatic int val(input int i, input bit narrow);
    if (i < 5) return narrow ? m_cnt2[i] : m_cnt[i];
    return narrow ? m_tot2 : m_tot;
  endfunction

  task automatic model_clear();
    foreach (m_cnt[i]) begin m_cnt[i] = 0; m_cnt2[i] = 0; end
    m_tot = 0; m_tot2 = 0; m_sat = 0; m_sat2 = 0;
    m_state = 0; m_k = 0; m_idx = 0; m_prev = 0; m_pprev = 0;
  endtask

  // applies the currently driven inputs to the model for the coming edge, then waits past that edge
  task automatic tick();
    logic [4:0] r;
    res_t e;
    disp_t d;
    r = votes & ~m_prev;
    if (m_state == 0)
      for (int i = 0; i < 5; i++)
        if (r[i]) begin
          if (m_cnt[i] < 255) m_cnt[i]++;
          if (m_cnt2[i] < 3) m_cnt2[i]++;
          if (m_tot < 255) m_tot++;
          if (m_tot2 < 3) m_tot2++;
        end
    foreach (m_cnt[i]) begin
      if (m_cnt[i] == 255) m_sat = 1;
      if (m_cnt2[i] == 3) m_sat2 = 1;
    end
    if (m_tot == 255) m_sat = 1;
    if (m_tot2 == 3) m_sat2 = 1;
    if (m_state == 2 && proximo && !m_pprev) begin
      m_idx = (m_idx + 1) % 6;
      d.idx = m_idx; d.c = val(m_idx, 0); d.c2 = val(m_idx, 1);
      disp_q.push_back(d);
    end
    if (m_state == 0 && finish) begin
      m_state = 1; m_k = 0;
      e.cyc = cyc + 5;
      win(m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3], e.venc, e.emp);
      win(m_cnt2[0], m_cnt2[1], m_cnt2[2], m_cnt2[3], e.venc2, e.emp2);
      e.tot = m_tot; e.sat = m_sat; e.c0 = m_cnt[0];
      e.tot2 = m_tot2; e.sat2 = m_sat2; e.c02 = m_cnt2[0];
      res_q.push_back(e);
    end else if (m_state == 1) begin
      m_k++;
      if (m_k == 4) begin m_state = 2; m_idx = 0; end
    end
    m_prev = votes;
    m_pprev = proximo;
    @(negedge clock);
  endtask

  logic [1:0] p_est = 0;
  logic [2:0] p_idx = 0;
  always @(negedge clock) begin : mon
    res_t e;
    disp_t d;
    if (estado == 2'd2 && p_est != 2'd2) begin
      if (res_q.size() == 0) chk("unexpected_result", int'(estado), 0);
      else begin
        e = res_q.pop_front();
        chk("entry_cycle", cyc, e.cyc);
        chk("vencedor", vencedor, e.venc);
        chk("empate", empate, e.emp);
        chk("total", total, e.tot);
        chk("saturado", saturado, e.sat);
        chk("entry_indice", indice, 0);
        chk("entry_contagem", contagem, e.c0);
        chk("vencedor_w2", vencedor2, e.venc2);
        chk("empate_w2", empate2, e.emp2);
        chk("total_w2", total2, e.tot2);
        chk("saturado_w2", saturado2, e.sat2);
        chk("entry_contagem_w2", contagem2, e.c02);
      end
    end else if (estado == 2'd2 && indice != p_idx) begin
      if (disp_q.size() == 0) chk("unexpected_advance", indice, p_idx);
      else begin
        d = disp_q.pop_front();
        chk("indice", indice, d.idx);
        chk("contagem", contagem, d.c);
        chk("contagem_w2", contagem2, d.c2);
      end
    end
    p_est = estado;
    p_idx = indice;
  end

  task automatic do_reset(input bit abort);
    votes = 0; finish = 0; proximo = 0;
    if (!abort) begin
      repeat (2) tick();
      chk("pending_results", res_q.size(), 0);
      chk("pending_display", disp_q.size(), 0);
    end
    res_q.delete();
    disp_q.delete();
    #2 reset = 1;
    #1;
    chk("rst_estado", estado, 0);
    chk("rst_indice", indice, 0);
    chk("rst_contagem", contagem, 0);
    chk("rst_total", total, 0);
    chk("rst_vencedor", vencedor, 7);
    chk("rst_empate", empate, 0);
    chk("rst_saturado", saturado, 0);
    chk("rst_total_w2", total2, 0);
    chk("rst_saturado_w2", saturado2, 0);
    model_clear();
    @(negedge clock);
    reset = 0;
  endtask

  task automatic pulse(input logic [4:0] m, input int n);
    repeat (n) begin
      votes = m;
      repeat (4) tick();
      votes = 0;
      repeat (4) tick();
    end
  endtask

  task automatic close_poll();
    finish = 1;
    tick();
    repeat (4) tick();
  endtask

  task automatic press(input int hold);
    proximo = 1;
    repeat (hold) tick();
    proximo = 0;
    repeat (2) tick();
  endtask

  initial begin
    model_clear();
    repeat (2) @(negedge clock);
    reset = 0;
    // three Arthur, two Mateus, one nulo, then full display walk
    pulse(5'b00001, 3);
    pulse(5'b00100, 2);
    pulse(5'b10000, 1);
    finish = 1;
    tick();
    chk("apurando_state", estado, 1);
    chk("vencedor_held", vencedor, 7);
    repeat (4) tick();
    repeat (6) press(1);
    press(20);
    pulse(5'b01011, 1);
    repeat (6) press(2);
    do_reset(0);
    // Leandro/Pablo tie
    pulse(5'b00010, 2);
    pulse(5'b01000, 2);
    close_poll();
    press(1);
    do_reset(0);
    // no votes
    close_poll();
    press(3);
    do_reset(0);
    // Pablo five times saturates the narrow instance
    pulse(5'b01000, 5);
    close_poll();
    repeat (5) press(1);
    do_reset(0);
    // reset while the winner search is in progress
    pulse(5'b00001, 1);
    finish = 1;
    repeat (3) tick();
    do_reset(1);
    pulse(5'b00100, 1);
    chk("after_abort_state", estado, 0);
    chk("after_abort_total", total, 1);
    close_poll();
    repeat (3) press(1);
    do_reset(0);
    // randomized elections
    for (int t = 0; t < 20; t++) begin
      repeat ($urandom_range(5, 40)) begin
        if ($urandom_range(0, 2) == 0) votes = 5'($urandom());
        tick();
      end
      finish = 1;
      if ($urandom_range(0, 1) == 1) votes = 5'($urandom());
      tick();
      finish = 1'($urandom_range(0, 1));
      repeat (4) tick();
      repeat ($urandom_range(3, 9)) begin
        if ($urandom_range(0, 2) == 0) votes = 5'($urandom());
        press($urandom_range(1, 6));
      end
      do_reset(0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
